gray_serial_decode_ctrl: RTL and testbench

Sequencer that converts Gray-coded words to binary bit-serially, MSB first, using a single XOR step reused over WIDTH cycles instead of a full combinational XOR chain. It sits between a Gray-code source (encoder/pointer capture) and a binary consumer. Both sides use valid/ready handshakes. Throughput is one word per WIDTH+2 cycles, in exchange for minimal logic.

---
 rtl/gray_pkg.sv | 18 +
 rtl/gray_serial_decode_ctrl.sv | 83 ++++++++
 tb/tb_gray_serial_decode_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared types and constants for the bit-serial Gray-to-binary sequencer.
package gray_pkg;

  // Sequencer states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int unsigned GRAY_W_DEFAULT = 4;

  // Bit-index counter width; a 1-bit word still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/gray_serial_decode_ctrl.sv
// Bit-serial Gray-to-binary converter: one XOR step reused over WIDTH cycles,
// MSB first, with valid/ready handshakes on both sides.
module gray_serial_decode_ctrl
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bin,
  output logic             busy
);

  localparam int unsigned IW = idx_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] gray_r;
  logic [WIDTH-1:0] work_r;
  logic [IW-1:0]    idx;
  logic             carry;

  logic             step_bit;
  logic [WIDTH-1:0] work_next;

  // Single XOR step: current bit is the Gray bit folded with the previous binary bit.
  always_comb begin
    step_bit       = gray_r[idx] ^ carry;
    work_next      = work_r;
    work_next[idx] = step_bit;
  end

  // Sequencer and datapath; out_bin only updates when the final bit lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gray_r    <= '0;
      work_r    <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
      out_bin   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            gray_r <= in_gray;
            work_r <= '0;
            idx    <= IW'(WIDTH - 1);
            carry  <= 1'b0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          work_r <= work_next;
          carry  <= step_bit;
          if (idx == '0) begin
            out_bin   <= work_next;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_gray_serial_decode_ctrl.sv
// Self-checking bench for gray_serial_decode_ctrl (WIDTH=4 and WIDTH=1 instances).
module tb_gray_serial_decode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] in_gray, out_bin;
  logic       in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [0:0] in_gray1, out_bin1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  gray_serial_decode_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_gray(in_gray),
    .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin), .busy(busy)
  );

  gray_serial_decode_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_gray(in_gray1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_bin(out_bin1), .busy(busy1)
  );

  // Golden model: binary bit i is the XOR of all Gray bits at or above i.
  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, check SHIFT latency/stability, stall, handshake.
  task automatic xfer(input logic [3:0] g, input int stall);
    int         n;
    logic [3:0] prev;
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    in_gray   = g;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    prev = out_bin;
    step();
    in_valid = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    n = 0;
    while (!out_valid && n < 50) begin
      chk("in_ready_shift", {31'd0, in_ready}, 32'd0);
      chk("out_bin_stable_shift", {28'd0, out_bin}, {28'd0, prev});
      step();
      n++;
    end
    chk("latency", n, 32'd4);
    chk("out_bin", {28'd0, out_bin}, {28'd0, g2b(g)});
    for (int i = 0; i < stall; i++) begin
      step();
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_bin", {28'd0, out_bin}, {28'd0, g2b(g)});
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [3:0] words[6];
    logic [3:0] q[$];
    logic [3:0] e;
    int         k, got, last, cyc;
    logic       acc;

    rst = 1'b1;
    in_valid = 1'b0; in_gray = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_gray1 = '0; out_ready1 = 1'b0;
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_bin", {28'd0, out_bin}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) rst = 1'b0;
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed stream from the test plan.
    xfer(4'b1010, 0);
    xfer(4'b1001, 0);
    xfer(4'b1000, 0);
    xfer(4'b0110, 0);
    xfer(4'b0101, 0);

    // Backpressure.
    xfer(4'b1000, 10);

    // in_valid held high continuously; word changes only after each accept.
    for (int i = 0; i < 6; i++) words[i] = 4'($urandom);
    out_ready = 1'b1; in_valid = 1'b1; in_gray = words[0];
    k = 0; got = 0; last = -1; cyc = 0;
    while (got < 6 && cyc < 200) begin
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        e = (q.size() > 0) ? q.pop_front() : 4'bx;
        chk("stream_bin", {28'd0, out_bin}, {28'd0, e});
        got++;
      end
      if (acc) begin
        q.push_back(g2b(in_gray));
        if (last >= 0) chk("stream_spacing", cyc - last, 32'd6);
        last = cyc;
      end
      step();
      cyc++;
      if (acc) begin
        k++;
        if (k < 6) in_gray = words[k];
        else in_valid = 1'b0;
      end
    end
    chk("stream_outputs", got, 32'd6);
    chk("stream_accepts", k, 32'd6);

    // Async reset two cycles into SHIFT.
    in_valid = 1'b1; in_gray = 4'b0110;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_bin", {28'd0, out_bin}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) rst = 1'b0;
    step();
    xfer(4'b0101, 0);

    // Exhaustive sweep with random stalls.
    for (int g = 0; g < 16; g++) xfer(4'(g), int'($urandom_range(0, 3)));

    // WIDTH=1 instance.
    out_ready1 = 1'b1;
    for (int v = 1; v >= 0; v--) begin
      in_valid1 = 1'b1; in_gray1 = 1'(v);
      chk("w1_in_ready", {31'd0, in_ready1}, 32'd1);
      step();
      in_valid1 = 1'b0;
      chk("w1_shift_valid", {31'd0, out_valid1}, 32'd0);
      step();
      chk("w1_valid", {31'd0, out_valid1}, 32'd1);
      chk("w1_bin", {31'd0, out_bin1}, 32'(v));
      step();
      chk("w1_done", {31'd0, out_valid1}, 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
